spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arb_pkg.sv | 20 ++
 rtl/spi_arbiter_if.sv | 29 ++
 rtl/spi_arbiter_rr_pick.sv | 24 ++
 rtl/spi_arbiter.sv | 175 +++++++++++++++++
 tb/tb_spi_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and sizing for the SPI arbiter.
package spi_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int IDX_W   = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_GUARD
  } arb_state_t;

  // Round-robin successor; wraps naturally because NUM_REQ is a power of two.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return IDX_W'(idx + 1'b1);
  endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// Requester-side and SPI-master-side signals of the arbiter.
// slave  : arbiter view
// master : environment view (requesters plus SPI master)
interface spi_arbiter_if;
  import spi_arb_pkg::*;

  logic [NUM_REQ-1:0]        REQ;
  logic [NUM_REQ*DATA_W-1:0] TX_DATA;
  logic [NUM_REQ-1:0]        GNT;
  logic [NUM_REQ-1:0]        DONE;
  logic [DATA_W-1:0]         RX_DATA;
  logic                      ERR;
  logic                      M_TX_EN;
  logic [DATA_W-1:0]         M_TX_DATA;
  logic [IDX_W-1:0]          M_CSI;
  logic                      M_TC;
  logic [DATA_W-1:0]         M_RX_DATA;

  modport slave (
    input  REQ, TX_DATA, M_TC, M_RX_DATA,
    output GNT, DONE, RX_DATA, ERR, M_TX_EN, M_TX_DATA, M_CSI
  );

  modport master (
    output REQ, TX_DATA, M_TC, M_RX_DATA,
    input  GNT, DONE, RX_DATA, ERR, M_TX_EN, M_TX_DATA, M_CSI
  );

endinterface

// File: rtl/spi_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or above ptr,
// wrapping from the top requester back to 0.
module rr_pick
  import spi_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  // Scan offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[IDX_W'(ptr + IDX_W'(i))]) begin
        idx   = IDX_W'(ptr + IDX_W'(i));
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among four requesters.
// Optional build macro: SPI_ARB_TIMEOUT_EN adds a WAIT-state watchdog that
// aborts a transfer after TIMEOUT_CYC cycles (ERR + DONE, RX_DATA = 0).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transfer; pick a requester when any REQ bit is set
// ST_START | one-cycle M_TX_EN strobe to the master
// ST_WAIT  | waiting for a rising edge on M_TC (or watchdog expiry)
// ST_GUARD | GNT low, DONE pulse in first cycle, spacing before IDLE
//
// GUARD_CYC counts every GNT-low cycle between two grants, including the
// IDLE arbitration cycle, so GUARD itself lasts GUARD_CYC-1 cycles (min 1).
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int GUARD_CYC   = 2
) (
  input  logic          CLK,
  input  logic          RST_,
  spi_arbiter_if.slave  bus
);

  localparam int GUARD_LEN = (GUARD_CYC > 1) ? GUARD_CYC - 1 : 1;
  localparam int GUARD_W   = $clog2(GUARD_LEN + 1);

  if (TIMEOUT_CYC < 1 || GUARD_CYC < 1) begin : g_param_check
    $error("spi_arbiter: TIMEOUT_CYC and GUARD_CYC must be >= 1");
  end

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, idx_q, pick_idx;
  logic                pick_valid;
  logic [NUM_REQ-1:0]  gnt_q, done_q;
  logic [DATA_W-1:0]   rx_q, tx_data_q;
  logic                tx_en_q;
  logic                tc_q, tc_rise;
  logic [GUARD_W-1:0]  guard_cnt_q;
  logic                capture, finish, abort, guard_exit;
  logic                timeout_hit;

  rr_pick u_rr_pick (
    .req   (bus.REQ),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign tc_rise = bus.M_TC & ~tc_q;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            err_q;

  // Watchdog down-counter: armed in START, terminal count in WAIT aborts.
  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      to_cnt_q <= '0;
    end else if (state_q == ST_START) begin
      to_cnt_q <= TO_W'(TIMEOUT_CYC - 1);
    end else if (state_q == ST_WAIT && to_cnt_q != '0) begin
      to_cnt_q <= to_cnt_q - 1'b1;
    end
  end

  assign timeout_hit = (state_q == ST_WAIT) && (to_cnt_q == '0);

  // ERR rides alongside the DONE pulse of an aborted transfer.
  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) err_q <= 1'b0;
    else       err_q <= abort;
  end

  assign bus.ERR = err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus.ERR     = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    guard_exit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          capture = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (tc_rise) begin
          finish  = 1'b1;
          state_d = ST_GUARD;
        end else if (timeout_hit) begin
          finish  = 1'b1;
          abort   = 1'b1;
          state_d = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (guard_cnt_q == '0) begin
          guard_exit = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered copy of M_TC; a level already high on WAIT entry is no edge.
  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) tc_q <= 1'b0;
    else       tc_q <= bus.M_TC;
  end

  // Guard spacing down-counter, loaded as the transfer finishes.
  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      guard_cnt_q <= '0;
    end else if (finish) begin
      guard_cnt_q <= GUARD_W'(GUARD_LEN - 1);
    end else if (state_q == ST_GUARD && guard_cnt_q != '0) begin
      guard_cnt_q <= guard_cnt_q - 1'b1;
    end
  end

  // Grant capture, completion pulses, received byte and rotation pointer.
  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      ptr_q     <= '0;
      idx_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      rx_q      <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      tx_en_q <= capture;
      done_q  <= finish ? (NUM_REQ'(1) << idx_q) : '0;
      if (capture) begin
        idx_q     <= pick_idx;
        gnt_q     <= NUM_REQ'(1) << pick_idx;
        tx_data_q <= bus.TX_DATA[pick_idx*DATA_W +: DATA_W];
      end
      if (finish) begin
        gnt_q <= '0;
        rx_q  <= abort ? '0 : bus.M_RX_DATA;
      end
      if (guard_exit) begin
        ptr_q <= next_idx(idx_q);
      end
    end
  end

  assign bus.GNT       = gnt_q;
  assign bus.DONE      = done_q;
  assign bus.RX_DATA   = rx_q;
  assign bus.M_TX_EN   = tx_en_q;
  assign bus.M_TX_DATA = tx_data_q;
  assign bus.M_CSI     = idx_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: directed vector table, hand-written
// corner sequences, and randomized transfers against a round-robin model.
module tb_spi_arbiter;
  import spi_arb_pkg::*;

  localparam int GUARD = 3;
  localparam int TMO   = 16;

  logic CLK = 1'b0;
  logic RST_;
  int   checks = 0;
  int   errors = 0;
  int   mptr   = 0;

  spi_arbiter_if bus();

  spi_arbiter #(.TIMEOUT_CYC(TMO), .GUARD_CYC(GUARD)) dut (
    .CLK  (CLK),
    .RST_ (RST_),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] txd;
    logic [7:0]  rx;
    int          dly;
    int          exp_idx;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: rotate the request vector so the pointer sits at bit 0, take the
  // lowest set bit, and map the offset back to a requester index.
  function automatic int model_pick(input logic [3:0] r);
    logic [7:0] dbl;
    dbl = {r, r} >> mptr;
    for (int i = 0; i < 4; i++) if (dbl[i]) return (mptr + i) % 4;
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},   32'(bus.GNT), 0);
    check({tag, "_done"},  32'(bus.DONE), 0);
    check({tag, "_rx"},    32'(bus.RX_DATA), 0);
    check({tag, "_err"},   32'(bus.ERR), 0);
    check({tag, "_txen"},  32'(bus.M_TX_EN), 0);
    check({tag, "_txd"},   32'(bus.M_TX_DATA), 0);
    check({tag, "_csi"},   32'(bus.M_CSI), 0);
  endtask

  // One full transfer starting in an IDLE cycle, ending in the next IDLE cycle.
  task automatic do_xfer(input logic [3:0] req, input logic [31:0] txd, input logic [7:0] rx,
                         input int dly, input bit drop, input int e, input logic [7:0] eb);
    logic [3:0] g;
    g = 4'(1 << e);
    bus.REQ = req;
    bus.TX_DATA = txd;
    tick();
    check("gnt_capture", 32'(bus.GNT), 32'(g));
    check("tx_en_start", 32'(bus.M_TX_EN), 1);
    check("csi", 32'(bus.M_CSI), 32'(e));
    check("tx_byte", 32'(bus.M_TX_DATA), 32'(eb));
    if (drop) bus.REQ = '0;
    bus.TX_DATA = $urandom;
    tick();
    check("tx_en_single", 32'(bus.M_TX_EN), 0);
    check("gnt_wait", 32'(bus.GNT), 32'(g));
    for (int i = 0; i < dly; i++) begin
      bus.TX_DATA = $urandom;
      tick();
      check("done_early", 32'(bus.DONE), 0);
      check("gnt_hold", 32'(bus.GNT), 32'(g));
    end
    bus.M_TC = 1'b1;
    bus.M_RX_DATA = rx;
    tick();
    check("done_pulse", 32'(bus.DONE), 32'(g));
    check("rx_data", 32'(bus.RX_DATA), 32'(rx));
    check("gnt_guard", 32'(bus.GNT), 0);
    check("err_clean", 32'(bus.ERR), 0);
    check("tx_byte_held", 32'(bus.M_TX_DATA), 32'(eb));
    bus.M_TC = 1'b0;
    bus.M_RX_DATA = 8'($urandom);
    for (int i = 0; i < GUARD - 1; i++) begin
      tick();
      check("done_fall", 32'(bus.DONE), 0);
      check("gnt_gap", 32'(bus.GNT), 0);
      check("rx_held", 32'(bus.RX_DATA), 32'(rx));
      check("tx_byte_guard", 32'(bus.M_TX_DATA), 32'(eb));
    end
    mptr = (e + 1) % 4;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "tb_spi_arbiter timeout");
  end

  initial begin
    int e;
    logic [3:0] r;
    logic [31:0] d;
    logic [7:0] x;

    vecs[0] = '{4'b0100, 32'h11A52233, 8'h3C, 0, 2, 8'hA5};
    vecs[1] = '{4'b0011, 32'hDEADBEEF, 8'h81, 1, 0, 8'hEF};
    vecs[2] = '{4'b0101, 32'h01234567, 8'h7E, 2, 2, 8'h23};
    vecs[3] = '{4'b1001, 32'h89ABCDEF, 8'hC3, 3, 3, 8'h89};
    vecs[4] = '{4'b0010, 32'hCAFEF00D, 8'h5A, 0, 1, 8'hF0};
    vecs[5] = '{4'b0001, 32'h5A5A5A77, 8'hE1, 4, 0, 8'h77};

    RST_ = 1'b0;
    bus.REQ = '0;
    bus.TX_DATA = '0;
    bus.M_TC = 1'b0;
    bus.M_RX_DATA = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("reset");
    RST_ = 1'b1;
    mptr = 0;

    // Directed table from reset (pointer starts at 0).
    for (int v = 0; v < 6; v++) begin
      do_xfer(vecs[v].req, vecs[v].txd, vecs[v].rx, vecs[v].dly, 1'b0,
              vecs[v].exp_idx, vecs[v].exp_byte);
    end

    // Request dropped after capture still completes.
    do_xfer(4'b0010, 32'h00004400, 8'h5E, 2, 1'b1, 1, 8'h44);

    // Reset mid-WAIT: outputs clear immediately, no DONE, pointer back to 0.
    e = model_pick(4'b0001);
    bus.REQ = 4'b0001;
    bus.TX_DATA = 32'h11223344;
    tick();
    check("abort_gnt", 32'(bus.GNT), 32'(1 << e));
    bus.REQ = '0;
    tick();
    tick();
    #2;
    RST_ = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge CLK);
    #1;
    check("rst_no_done", 32'(bus.DONE), 0);
    RST_ = 1'b1;
    mptr = 0;
    tick();
    check("post_rst_done", 32'(bus.DONE), 0);
    check("post_rst_gnt", 32'(bus.GNT), 0);

    // All four requesting continuously: strict rotation 0,1,2,3,0,1,2,3.
    for (int k = 0; k < 8; k++) begin
      d = $urandom;
      do_xfer(4'b1111, d, 8'(k + 8'h10), k % 3, 1'b0, k % 4, d[8*(k%4) +: 8]);
    end
    bus.REQ = '0;

    do_xfer(4'b1000, 32'hB7000000, 8'h42, 1, 1'b0, 3, 8'hB7);

    // M_TC already high entering WAIT is not a completion.
    e = model_pick(4'b0100);
    bus.REQ = 4'b0100;
    bus.TX_DATA = 32'h00990000;
    bus.M_TC = 1'b1;
    tick();
    check("tchigh_gnt", 32'(bus.GNT), 32'(1 << e));
    bus.REQ = '0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("tchigh_no_done", 32'(bus.DONE), 0);
    end
    bus.M_TC = 1'b0;
    tick();
    check("tclow_no_done", 32'(bus.DONE), 0);
    bus.M_TC = 1'b1;
    bus.M_RX_DATA = 8'h96;
    tick();
    check("tc_rerise_done", 32'(bus.DONE), 32'(1 << e));
    check("tc_rerise_rx", 32'(bus.RX_DATA), 32'h96);
    bus.M_TC = 1'b0;
    for (int i = 0; i < GUARD - 1; i++) tick();
    mptr = (e + 1) % 4;

`ifdef SPI_ARB_TIMEOUT_EN
    // Master never completes: abort TMO cycles after WAIT entry.
    e = model_pick(4'b1000);
    bus.REQ = 4'b1000;
    bus.TX_DATA = 32'h6D000000;
    tick();
    check("to_gnt", 32'(bus.GNT), 32'(1 << e));
    bus.REQ = '0;
    tick();
    for (int i = 0; i < TMO - 1; i++) begin
      tick();
      check("to_no_done", 32'(bus.DONE), 0);
      check("to_no_err", 32'(bus.ERR), 0);
    end
    tick();
    check("to_err", 32'(bus.ERR), 1);
    check("to_done", 32'(bus.DONE), 32'(1 << e));
    check("to_rx_zero", 32'(bus.RX_DATA), 0);
    for (int i = 0; i < GUARD - 1; i++) begin
      tick();
      check("to_err_fall", 32'(bus.ERR), 0);
    end
    mptr = (e + 1) % 4;
`endif

    // Randomized transfers against the rotation model.
    for (int k = 0; k < 40; k++) begin
      r = 4'($urandom_range(1, 15));
      d = $urandom;
      x = 8'($urandom);
      e = model_pick(r);
      do_xfer(r, d, x, $urandom_range(0, 4), 1'($urandom_range(0, 1)), e, d[8*e +: 8]);
    end
    bus.REQ = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
